// File: rtl/vx_warp_ctl_recv.sv
`default_nettype none
// ============================================================================
// Module   : vx_warp_ctl_recv
// Purpose  : Receiving end of the warp-control channel inside the scheduler.
//            Consumes single-cycle tmc / wspawn / split / join / barrier
//            commands and maintains per-warp active bits, thread masks, the
//            IPDOM reconvergence stacks and barrier stalls. Emits redirect,
//            spawn and global-barrier-request pulses.
// Ports    : clk, reset              - clock, synchronous active-high reset
//            wctl_* / tmc_* / wspawn_* / split_* / join_* / bar_*
//                                    - command pulse and its fields
//            gbar_req_*, gbar_rsp_*  - global barrier request / release
//            active_warps, stalled_warps, thread_masks, ipdom_err
//                                    - registered warp state
//            redirect_*, spawn_*     - 1-cycle event pulses
// Revision : 1.0 - initial release
// ============================================================================
module vx_warp_ctl_recv #(
    parameter int NUM_WARPS    = 4,
    parameter int NUM_THREADS  = 4,
    parameter int NUM_BARRIERS = 4,
    parameter int IPDOM_DEPTH  = 8,
    parameter int XLEN         = 32,
    parameter logic [XLEN-1:0] STARTUP_ADDR = XLEN'(32'h8000_0000),
    localparam int c_NW = (NUM_WARPS    > 1) ? $clog2(NUM_WARPS)    : 1,
    localparam int c_NB = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              wctl_valid,
    input  logic [c_NW-1:0]                   wctl_wid,
    input  logic                              tmc_valid,
    input  logic [NUM_THREADS-1:0]            tmc_tmask,
    input  logic                              wspawn_valid,
    input  logic [NUM_WARPS-1:0]              wspawn_wmask,
    input  logic [XLEN-1:0]                   wspawn_pc,
    input  logic                              split_valid,
    input  logic                              split_is_dvg,
    input  logic [NUM_THREADS-1:0]            split_then_tmask,
    input  logic [NUM_THREADS-1:0]            split_else_tmask,
    input  logic [XLEN-1:0]                   split_next_pc,
    input  logic                              join_valid,
    input  logic                              join_is_dvg,
    input  logic                              bar_valid,
    input  logic [c_NB-1:0]                   bar_id,
    input  logic                              bar_is_global,
    input  logic [c_NW-1:0]                   bar_size_m1,
    output logic                              gbar_req_valid,
    output logic [c_NB-1:0]                   gbar_req_id,
    output logic [c_NW-1:0]                   gbar_req_size_m1,
    input  logic                              gbar_rsp_valid,
    input  logic [c_NB-1:0]                   gbar_rsp_id,
    output logic [NUM_WARPS-1:0]              active_warps,
    output logic [NUM_WARPS-1:0]              stalled_warps,
    output logic [NUM_WARPS*NUM_THREADS-1:0]  thread_masks,
    output logic                              redirect_valid,
    output logic [c_NW-1:0]                   redirect_wid,
    output logic [XLEN-1:0]                   redirect_pc,
    output logic                              spawn_valid,
    output logic [NUM_WARPS-1:0]              spawn_wmask,
    output logic [XLEN-1:0]                   spawn_pc,
    output logic [NUM_WARPS-1:0]              ipdom_err
);

    localparam int c_SPW  = $clog2(IPDOM_DEPTH + 1);
    localparam int c_IDXW = $clog2(IPDOM_DEPTH);
    // A divergent split needs two free entries: sp must not exceed DEPTH-2.
    localparam logic [c_SPW-1:0]       c_SP_PUSH_MAX = c_SPW'(IPDOM_DEPTH - 2);
    localparam logic [c_SPW-1:0]       c_SP_TWO      = c_SPW'(2);
    localparam logic [c_SPW-1:0]       c_SP_ONE      = c_SPW'(1);
    localparam logic [c_NW:0]          c_CNT_ONE     = (c_NW+1)'(1);
    localparam logic [NUM_WARPS-1:0]   c_WARP0       = NUM_WARPS'(1);
    localparam logic [NUM_THREADS-1:0] c_THREAD0     = NUM_THREADS'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_WARPS-1:0]   r_active;
    logic [NUM_WARPS-1:0]   r_stalled;
    logic [NUM_WARPS-1:0]   r_err;
    logic [NUM_THREADS-1:0] r_tmask     [NUM_WARPS];
    logic [c_SPW-1:0]       r_sp        [NUM_WARPS];
    logic [NUM_WARPS-1:0]   r_lbar_mask [NUM_BARRIERS];
    logic [c_NW:0]          r_lbar_cnt  [NUM_BARRIERS];
    logic [NUM_WARPS-1:0]   r_gbar_mask [NUM_BARRIERS];
    logic                   r_boot;

    // Stack payload has no reset: emptiness is tracked solely by r_sp.
    logic [NUM_THREADS-1:0] r_stk_tmask [NUM_WARPS][IPDOM_DEPTH];
    logic [XLEN-1:0]        r_stk_pc    [NUM_WARPS][IPDOM_DEPTH];
    logic                   r_stk_else  [NUM_WARPS][IPDOM_DEPTH];

    logic                   r_redirect_valid;
    logic [c_NW-1:0]        r_redirect_wid;
    logic [XLEN-1:0]        r_redirect_pc;
    logic                   r_spawn_valid;
    logic [NUM_WARPS-1:0]   r_spawn_wmask;
    logic [XLEN-1:0]        r_spawn_pc;
    logic                   r_gbar_req_valid;
    logic [c_NB-1:0]        r_gbar_req_id;
    logic [c_NW-1:0]        r_gbar_req_size_m1;

    // ------------------------------------------------------------------
    // Next-state computation
    // ------------------------------------------------------------------
    logic [NUM_WARPS-1:0]   w_active;
    logic [NUM_WARPS-1:0]   w_stalled;
    logic [NUM_WARPS-1:0]   w_err;
    logic [NUM_THREADS-1:0] w_tmask     [NUM_WARPS];
    logic [c_SPW-1:0]       w_sp        [NUM_WARPS];
    logic [NUM_WARPS-1:0]   w_lbar_mask [NUM_BARRIERS];
    logic [c_NW:0]          w_lbar_cnt  [NUM_BARRIERS];
    logic [NUM_WARPS-1:0]   w_gbar_mask [NUM_BARRIERS];
    logic                   w_push;
    logic                   w_redirect_valid;
    logic [XLEN-1:0]        w_redirect_pc;
    logic [NUM_WARPS-1:0]   w_spawn_set;
    logic                   w_gbar_req_valid;

    logic [c_SPW-1:0]       w_sp_cur;
    logic [c_SPW-1:0]       w_sp_top;
    logic [c_IDXW-1:0]      w_push_lo;
    logic [c_IDXW-1:0]      w_push_hi;
    logic [c_IDXW-1:0]      w_top_idx;
    logic [NUM_WARPS-1:0]   w_wid_oh;

    assign w_sp_cur  = r_sp[wctl_wid];
    assign w_sp_top  = w_sp_cur - c_SP_ONE;
    assign w_push_lo = w_sp_cur[c_IDXW-1:0];
    assign w_push_hi = w_push_lo + c_IDXW'(1);
    assign w_top_idx = w_sp_top[c_IDXW-1:0];
    assign w_wid_oh  = c_WARP0 << wctl_wid;

    // Commands are applied as a sequence: split/join, barrier, wspawn, tmc.
    // Later stages overwrite earlier ones, so tmc owns the final mask.
    // A divergent split and a divergent join in the same command are not
    // expected from commit; if both appear, the split takes precedence.
    always_comb begin
        w_active         = r_active;
        w_stalled        = r_stalled;
        w_err            = r_err;
        w_tmask          = r_tmask;
        w_sp             = r_sp;
        w_lbar_mask      = r_lbar_mask;
        w_lbar_cnt       = r_lbar_cnt;
        w_gbar_mask      = r_gbar_mask;
        w_push           = 1'b0;
        w_redirect_valid = 1'b0;
        w_redirect_pc    = '0;
        w_spawn_set      = '0;
        w_gbar_req_valid = 1'b0;

        // Global release comes first so a same-cycle arrival on the same
        // id is recorded into a fresh mask.
        if (gbar_rsp_valid) begin
            w_stalled                = w_stalled & ~r_gbar_mask[gbar_rsp_id];
            w_gbar_mask[gbar_rsp_id] = '0;
        end

        if (wctl_valid) begin
            if (split_valid && split_is_dvg) begin
                if (w_sp_cur <= c_SP_PUSH_MAX) begin
                    w_push             = 1'b1;
                    w_sp[wctl_wid]     = w_sp_cur + c_SP_TWO;
                    w_tmask[wctl_wid]  = split_then_tmask;
                end else begin
                    w_err[wctl_wid]    = 1'b1;
                end
            end else if (join_valid && join_is_dvg) begin
                if (w_sp_cur == '0) begin
                    w_err[wctl_wid]    = 1'b1;
                end else begin
                    w_sp[wctl_wid]     = w_sp_top;
                    w_tmask[wctl_wid]  = r_stk_tmask[wctl_wid][w_top_idx];
                    if (r_stk_else[wctl_wid][w_top_idx]) begin
                        w_redirect_valid = 1'b1;
                        w_redirect_pc    = r_stk_pc[wctl_wid][w_top_idx];
                    end
                end
            end

            if (bar_valid) begin
                if (bar_is_global) begin
                    w_stalled[wctl_wid]  = 1'b1;
                    w_gbar_mask[bar_id]  = w_gbar_mask[bar_id] | w_wid_oh;
                    w_gbar_req_valid     = 1'b1;
                end else if (!r_lbar_mask[bar_id][wctl_wid]) begin
                    // The last arrival releases everyone and never stalls.
                    if (r_lbar_cnt[bar_id] == {1'b0, bar_size_m1}) begin
                        w_stalled           = w_stalled & ~(r_lbar_mask[bar_id] | w_wid_oh);
                        w_lbar_mask[bar_id] = '0;
                        w_lbar_cnt[bar_id]  = '0;
                    end else begin
                        w_lbar_mask[bar_id] = r_lbar_mask[bar_id] | w_wid_oh;
                        w_lbar_cnt[bar_id]  = r_lbar_cnt[bar_id] + c_CNT_ONE;
                        w_stalled[wctl_wid] = 1'b1;
                    end
                end
            end

            if (wspawn_valid) begin
                w_spawn_set = wspawn_wmask & ~r_active;
                w_active    = w_active | w_spawn_set;
                for (int w = 0; w < NUM_WARPS; w++) begin
                    if (w_spawn_set[w]) begin
                        w_tmask[w] = c_THREAD0;
                    end
                end
            end

            if (tmc_valid) begin
                w_tmask[wctl_wid] = tmc_tmask;
                if (tmc_tmask == '0) begin
                    w_active[wctl_wid] = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_active           <= c_WARP0;
            r_stalled          <= '0;
            r_err              <= '0;
            r_boot             <= 1'b1;
            for (int w = 0; w < NUM_WARPS; w++) begin
                r_tmask[w] <= (w == 0) ? c_THREAD0 : '0;
                r_sp[w]    <= '0;
            end
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                r_lbar_mask[b] <= '0;
                r_lbar_cnt[b]  <= '0;
                r_gbar_mask[b] <= '0;
            end
            r_redirect_valid   <= 1'b0;
            r_redirect_wid     <= '0;
            r_redirect_pc      <= '0;
            r_spawn_valid      <= 1'b0;
            r_spawn_wmask      <= '0;
            r_spawn_pc         <= '0;
            r_gbar_req_valid   <= 1'b0;
            r_gbar_req_id      <= '0;
            r_gbar_req_size_m1 <= '0;
        end else begin
            r_active    <= w_active;
            r_stalled   <= w_stalled;
            r_err       <= w_err;
            r_tmask     <= w_tmask;
            r_sp        <= w_sp;
            r_lbar_mask <= w_lbar_mask;
            r_lbar_cnt  <= w_lbar_cnt;
            r_gbar_mask <= w_gbar_mask;
            r_boot      <= 1'b0;

            r_redirect_valid <= w_redirect_valid;
            r_redirect_wid   <= w_redirect_valid ? wctl_wid : '0;
            r_redirect_pc    <= w_redirect_pc;

            // First cycle after reset announces warp 0 at the boot address.
            r_spawn_valid <= r_boot | (|w_spawn_set);
            r_spawn_wmask <= (r_boot ? c_WARP0 : '0) | w_spawn_set;
            r_spawn_pc    <= r_boot ? STARTUP_ADDR : ((|w_spawn_set) ? wspawn_pc : '0);

            r_gbar_req_valid   <= w_gbar_req_valid;
            r_gbar_req_id      <= w_gbar_req_valid ? bar_id : '0;
            r_gbar_req_size_m1 <= w_gbar_req_valid ? bar_size_m1 : '0;
        end
    end

    // Divergent split: {current mask, reconverge} below {else mask, else pc}.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stk_tmask[wctl_wid][w_push_lo] <= r_tmask[wctl_wid];
            r_stk_pc[wctl_wid][w_push_lo]    <= '0;
            r_stk_else[wctl_wid][w_push_lo]  <= 1'b0;
            r_stk_tmask[wctl_wid][w_push_hi] <= split_else_tmask;
            r_stk_pc[wctl_wid][w_push_hi]    <= split_next_pc;
            r_stk_else[wctl_wid][w_push_hi]  <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_WARPS; g++) begin : g_tmask_out
        assign thread_masks[g*NUM_THREADS +: NUM_THREADS] = r_tmask[g];
    end

    assign active_warps     = r_active;
    assign stalled_warps    = r_stalled;
    assign ipdom_err        = r_err;
    assign redirect_valid   = r_redirect_valid;
    assign redirect_wid     = r_redirect_wid;
    assign redirect_pc      = r_redirect_pc;
    assign spawn_valid      = r_spawn_valid;
    assign spawn_wmask      = r_spawn_wmask;
    assign spawn_pc         = r_spawn_pc;
    assign gbar_req_valid   = r_gbar_req_valid;
    assign gbar_req_id      = r_gbar_req_id;
    assign gbar_req_size_m1 = r_gbar_req_size_m1;

endmodule
`default_nettype wire

// File: tb/tb_vx_warp_ctl_recv.sv
`default_nettype none
// ============================================================================
// Module   : tb_vx_warp_ctl_recv
// Purpose  : Self-checking bench for vx_warp_ctl_recv: directed vector table,
//            hand-written multi-cycle sequences and a randomized run against
//            a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vx_warp_ctl_recv;

    logic        clk = 1'b0;
    logic        reset;
    logic        wctl_valid;
    logic [1:0]  wctl_wid;
    logic        tmc_valid;
    logic [3:0]  tmc_tmask;
    logic        wspawn_valid;
    logic [3:0]  wspawn_wmask;
    logic [31:0] wspawn_pc;
    logic        split_valid, split_is_dvg;
    logic [3:0]  split_then_tmask, split_else_tmask;
    logic [31:0] split_next_pc;
    logic        join_valid, join_is_dvg;
    logic        bar_valid;
    logic [1:0]  bar_id;
    logic        bar_is_global;
    logic [1:0]  bar_size_m1;
    logic        gbar_req_valid;
    logic [1:0]  gbar_req_id;
    logic [1:0]  gbar_req_size_m1;
    logic        gbar_rsp_valid;
    logic [1:0]  gbar_rsp_id;
    logic [3:0]  active_warps, stalled_warps, ipdom_err;
    logic [15:0] thread_masks;
    logic        redirect_valid;
    logic [1:0]  redirect_wid;
    logic [31:0] redirect_pc;
    logic        spawn_valid;
    logic [3:0]  spawn_wmask;
    logic [31:0] spawn_pc;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    vx_warp_ctl_recv #(
        .NUM_WARPS(4), .NUM_THREADS(4), .NUM_BARRIERS(4),
        .IPDOM_DEPTH(8), .XLEN(32), .STARTUP_ADDR(32'h8000_0000)
    ) dut (
        .clk(clk), .reset(reset),
        .wctl_valid(wctl_valid), .wctl_wid(wctl_wid),
        .tmc_valid(tmc_valid), .tmc_tmask(tmc_tmask),
        .wspawn_valid(wspawn_valid), .wspawn_wmask(wspawn_wmask), .wspawn_pc(wspawn_pc),
        .split_valid(split_valid), .split_is_dvg(split_is_dvg),
        .split_then_tmask(split_then_tmask), .split_else_tmask(split_else_tmask),
        .split_next_pc(split_next_pc),
        .join_valid(join_valid), .join_is_dvg(join_is_dvg),
        .bar_valid(bar_valid), .bar_id(bar_id), .bar_is_global(bar_is_global),
        .bar_size_m1(bar_size_m1),
        .gbar_req_valid(gbar_req_valid), .gbar_req_id(gbar_req_id),
        .gbar_req_size_m1(gbar_req_size_m1),
        .gbar_rsp_valid(gbar_rsp_valid), .gbar_rsp_id(gbar_rsp_id),
        .active_warps(active_warps), .stalled_warps(stalled_warps),
        .thread_masks(thread_masks),
        .redirect_valid(redirect_valid), .redirect_wid(redirect_wid),
        .redirect_pc(redirect_pc),
        .spawn_valid(spawn_valid), .spawn_wmask(spawn_wmask), .spawn_pc(spawn_pc),
        .ipdom_err(ipdom_err)
    );

    // ------------------------------------------------------------------
    // Vector record: one command plus the full expected state after it
    // ------------------------------------------------------------------
    typedef struct {
        logic [1:0]  wid;
        logic        tmc;  logic [3:0] tmask;
        logic        spn;  logic [3:0] wmask;
        logic [31:0] pc;
        logic        spl;  logic jn; logic dvg;
        logic [3:0]  thn;  logic [3:0] els;
        logic        bar;  logic glob; logic [1:0] bid; logic [1:0] sz;
        logic        rsp;  logic [1:0] rid;
        logic [3:0]  e_act; logic [3:0] e_stl; logic [15:0] e_msk; logic [3:0] e_err;
        logic        e_rdr; logic e_spn; logic [3:0] e_swm; logic e_gbr;
    } vec_t;

    function automatic vec_t idle_vec();
        vec_t v;
        v.wid = '0; v.tmc = 0; v.tmask = '0; v.spn = 0; v.wmask = '0; v.pc = '0;
        v.spl = 0; v.jn = 0; v.dvg = 0; v.thn = '0; v.els = '0;
        v.bar = 0; v.glob = 0; v.bid = '0; v.sz = '0; v.rsp = 0; v.rid = '0;
        v.e_act = '0; v.e_stl = '0; v.e_msk = '0; v.e_err = '0;
        v.e_rdr = 0; v.e_spn = 0; v.e_swm = '0; v.e_gbr = 0;
        return v;
    endfunction

    function automatic vec_t ex(vec_t v, logic [3:0] a, logic [3:0] s,
                                logic [15:0] m, logic [3:0] e);
        v.e_act = a; v.e_stl = s; v.e_msk = m; v.e_err = e;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(string tag, logic [3:0] ea, logic [3:0] es,
                             logic [15:0] em, logic [3:0] ee,
                             logic er, logic [1:0] erw, logic [31:0] erpc,
                             logic esp, logic [3:0] eswm, logic [31:0] espc,
                             logic eg, logic [1:0] egid, logic [1:0] egsz);
        check({tag, ".active"},   active_warps,  ea);
        check({tag, ".stalled"},  stalled_warps, es);
        check({tag, ".tmasks"},   thread_masks,  em);
        check({tag, ".ipdom_err"}, ipdom_err,    ee);
        check({tag, ".redir_v"},  redirect_valid, er);
        if (er) begin
            check({tag, ".redir_wid"}, redirect_wid, erw);
            check({tag, ".redir_pc"},  redirect_pc,  erpc);
        end
        check({tag, ".spawn_v"},  spawn_valid, esp);
        if (esp) begin
            check({tag, ".spawn_wm"}, spawn_wmask, eswm);
            check({tag, ".spawn_pc"}, spawn_pc,    espc);
        end
        check({tag, ".gbar_v"},   gbar_req_valid, eg);
        if (eg) begin
            check({tag, ".gbar_id"}, gbar_req_id,      egid);
            check({tag, ".gbar_sz"}, gbar_req_size_m1, egsz);
        end
    endtask

    task automatic clear_inputs();
        wctl_valid = 0; wctl_wid = '0; tmc_valid = 0; tmc_tmask = '0;
        wspawn_valid = 0; wspawn_wmask = '0; wspawn_pc = '0;
        split_valid = 0; split_is_dvg = 0; split_then_tmask = '0;
        split_else_tmask = '0; split_next_pc = '0;
        join_valid = 0; join_is_dvg = 0;
        bar_valid = 0; bar_id = '0; bar_is_global = 0; bar_size_m1 = '0;
        gbar_rsp_valid = 0; gbar_rsp_id = '0;
    endtask

    task automatic drive_cycle(vec_t v);
        @(negedge clk);
        wctl_wid = v.wid; tmc_valid = v.tmc; tmc_tmask = v.tmask;
        wspawn_valid = v.spn; wspawn_wmask = v.wmask; wspawn_pc = v.pc;
        split_valid = v.spl; split_is_dvg = v.dvg; split_then_tmask = v.thn;
        split_else_tmask = v.els; split_next_pc = v.pc;
        join_valid = v.jn; join_is_dvg = v.dvg;
        bar_valid = v.bar; bar_id = v.bid; bar_is_global = v.glob; bar_size_m1 = v.sz;
        gbar_rsp_valid = v.rsp; gbar_rsp_id = v.rid;
        wctl_valid = v.tmc | v.spn | v.spl | v.jn | v.bar;
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic reset_and_boot(string tag);
        @(negedge clk);
        clear_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        check_all({tag, ".in_reset"}, 4'b0001, 4'b0000, 16'h0001, 4'b0000,
                  0, 2'd0, 32'h0, 0, 4'h0, 32'h0, 0, 2'd0, 2'd0);
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;
        check_all({tag, ".boot"}, 4'b0001, 4'b0000, 16'h0001, 4'b0000,
                  0, 2'd0, 32'h0, 1, 4'b0001, 32'h8000_0000, 0, 2'd0, 2'd0);
    endtask

    // ------------------------------------------------------------------
    // Reference model: per-warp stacks as queues, barriers as warp sets
    // ------------------------------------------------------------------
    typedef struct { logic [3:0] m; logic [31:0] pc; logic el; } ent_t;

    logic [3:0] m_active, m_stalled, m_err;
    logic [3:0] m_mask [4];
    ent_t       m_stk  [4][$];
    logic [3:0] m_lbar [4];
    logic [3:0] m_gbar [4];
    logic       e_rdr, e_spn, e_gbr;
    logic [1:0] e_rwid, e_gid, e_gsz;
    logic [31:0] e_rpc, e_spc;
    logic [3:0] e_swm;

    task automatic model_reset();
        m_active = 4'b0001; m_stalled = '0; m_err = '0;
        for (int i = 0; i < 4; i++) begin
            m_mask[i] = (i == 0) ? 4'b0001 : 4'b0000;
            m_stk[i].delete();
            m_lbar[i] = '0;
            m_gbar[i] = '0;
        end
    endtask

    task automatic model_step();
        int   w;
        ent_t e;
        logic [3:0] fresh;
        w = int'(wctl_wid);
        e_rdr = 0; e_rwid = '0; e_rpc = '0; e_spn = 0; e_swm = '0; e_spc = '0;
        e_gbr = 0; e_gid = '0; e_gsz = '0;
        if (gbar_rsp_valid) begin
            m_stalled &= ~m_gbar[gbar_rsp_id];
            m_gbar[gbar_rsp_id] = '0;
        end
        if (wctl_valid) begin
            if (split_valid && split_is_dvg) begin
                if (m_stk[w].size() + 2 <= 8) begin
                    m_stk[w].push_back('{m: m_mask[w], pc: 32'h0, el: 1'b0});
                    m_stk[w].push_back('{m: split_else_tmask, pc: split_next_pc, el: 1'b1});
                    m_mask[w] = split_then_tmask;
                end else begin
                    m_err[w] = 1'b1;
                end
            end else if (join_valid && join_is_dvg) begin
                if (m_stk[w].size() == 0) begin
                    m_err[w] = 1'b1;
                end else begin
                    e = m_stk[w].pop_back();
                    m_mask[w] = e.m;
                    if (e.el) begin e_rdr = 1; e_rwid = wctl_wid; e_rpc = e.pc; end
                end
            end
            if (bar_valid) begin
                if (bar_is_global) begin
                    m_stalled[w] = 1'b1;
                    m_gbar[bar_id][w] = 1'b1;
                    e_gbr = 1; e_gid = bar_id; e_gsz = bar_size_m1;
                end else if (!m_lbar[bar_id][w]) begin
                    if ($countones(m_lbar[bar_id]) == int'(bar_size_m1)) begin
                        m_stalled &= ~m_lbar[bar_id];
                        m_stalled[w] = 1'b0;
                        m_lbar[bar_id] = '0;
                    end else begin
                        m_lbar[bar_id][w] = 1'b1;
                        m_stalled[w] = 1'b1;
                    end
                end
            end
            if (wspawn_valid) begin
                fresh = wspawn_wmask & ~m_active;
                for (int i = 0; i < 4; i++) begin
                    if (fresh[i]) begin m_active[i] = 1'b1; m_mask[i] = 4'b0001; end
                end
                if (fresh != 0) begin e_spn = 1; e_swm = fresh; e_spc = wspawn_pc; end
            end
            if (tmc_valid) begin
                m_mask[w] = tmc_tmask;
                if (tmc_tmask == 0) m_active[w] = 1'b0;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        vec_t v;
        vec_t tbl[$];
        clear_inputs();
        reset = 1;

        // Directed table, applied in order from the post-boot state.
        v = idle_vec(); v.spn = 1; v.wmask = 4'b1110; v.pc = 32'h100;
        v = ex(v, 4'b1111, 4'b0000, 16'h1111, 4'b0000); v.e_spn = 1; v.e_swm = 4'b1110; tbl.push_back(v);
        v = idle_vec(); v.wid = 2; v.tmc = 1; v.tmask = 4'b0000;
        v = ex(v, 4'b1011, 4'b0000, 16'h1011, 4'b0000); tbl.push_back(v);
        v = idle_vec(); v.wid = 0; v.tmc = 1; v.tmask = 4'b1111;
        v = ex(v, 4'b1011, 4'b0000, 16'h101F, 4'b0000); tbl.push_back(v);
        v = idle_vec(); v.spl = 1; v.dvg = 1; v.thn = 4'b0011; v.els = 4'b1100; v.pc = 32'h200;
        v = ex(v, 4'b1011, 4'b0000, 16'h1013, 4'b0000); tbl.push_back(v);
        v = idle_vec(); v.jn = 1; v.dvg = 1; v.pc = 32'h200;
        v = ex(v, 4'b1011, 4'b0000, 16'h101C, 4'b0000); v.e_rdr = 1; tbl.push_back(v);
        v = idle_vec(); v.jn = 1; v.dvg = 1;
        v = ex(v, 4'b1011, 4'b0000, 16'h101F, 4'b0000); tbl.push_back(v);
        v = idle_vec(); v.spl = 1; v.dvg = 0; v.thn = 4'b0001; v.els = 4'b1110;
        v = ex(v, 4'b1011, 4'b0000, 16'h101F, 4'b0000); tbl.push_back(v);
        v = idle_vec(); v.jn = 1; v.dvg = 0;
        v = ex(v, 4'b1011, 4'b0000, 16'h101F, 4'b0000); tbl.push_back(v);
        v = idle_vec(); v.jn = 1; v.dvg = 1;
        v = ex(v, 4'b1011, 4'b0000, 16'h101F, 4'b0001); tbl.push_back(v);
        v = idle_vec(); v.wid = 0; v.bar = 1; v.bid = 1; v.sz = 2;
        v = ex(v, 4'b1011, 4'b0001, 16'h101F, 4'b0001); tbl.push_back(v);
        v = idle_vec(); v.wid = 0; v.bar = 1; v.bid = 1; v.sz = 2;
        v = ex(v, 4'b1011, 4'b0001, 16'h101F, 4'b0001); tbl.push_back(v);
        v = idle_vec(); v.wid = 1; v.bar = 1; v.bid = 1; v.sz = 2;
        v = ex(v, 4'b1011, 4'b0011, 16'h101F, 4'b0001); tbl.push_back(v);
        v = idle_vec(); v.wid = 2; v.bar = 1; v.bid = 1; v.sz = 2;
        v = ex(v, 4'b1011, 4'b0000, 16'h101F, 4'b0001); tbl.push_back(v);
        v = idle_vec(); v.wid = 1; v.bar = 1; v.bid = 2; v.sz = 0;
        v = ex(v, 4'b1011, 4'b0000, 16'h101F, 4'b0001); tbl.push_back(v);
        v = idle_vec(); v.wid = 3; v.bar = 1; v.glob = 1; v.bid = 0; v.sz = 3;
        v = ex(v, 4'b1011, 4'b1000, 16'h101F, 4'b0001); v.e_gbr = 1; tbl.push_back(v);
        v = idle_vec(); v.rsp = 1; v.rid = 1;
        v = ex(v, 4'b1011, 4'b1000, 16'h101F, 4'b0001); tbl.push_back(v);
        v = idle_vec(); v.rsp = 1; v.rid = 0;
        v = ex(v, 4'b1011, 4'b0000, 16'h101F, 4'b0001); tbl.push_back(v);
        v = idle_vec(); v.wid = 1; v.bar = 1; v.glob = 1; v.bid = 0; v.sz = 1; v.rsp = 1; v.rid = 0;
        v = ex(v, 4'b1011, 4'b0010, 16'h101F, 4'b0001); v.e_gbr = 1; tbl.push_back(v);
        v = idle_vec(); v.rsp = 1; v.rid = 0;
        v = ex(v, 4'b1011, 4'b0000, 16'h101F, 4'b0001); tbl.push_back(v);
        v = idle_vec(); v.wid = 1; v.bar = 1; v.glob = 1; v.bid = 3; v.sz = 0;
        v = ex(v, 4'b1011, 4'b0010, 16'h101F, 4'b0001); v.e_gbr = 1; tbl.push_back(v);
        v = idle_vec(); v.wid = 1; v.tmc = 1; v.tmask = 4'b0000;
        v = ex(v, 4'b1001, 4'b0010, 16'h100F, 4'b0001); tbl.push_back(v);
        v = idle_vec(); v.rsp = 1; v.rid = 3;
        v = ex(v, 4'b1001, 4'b0000, 16'h100F, 4'b0001); tbl.push_back(v);
        v = idle_vec(); v.wid = 2; v.spn = 1; v.wmask = 4'b0100; v.pc = 32'h300; v.tmc = 1; v.tmask = 4'b0110;
        v = ex(v, 4'b1101, 4'b0000, 16'h160F, 4'b0001); v.e_spn = 1; v.e_swm = 4'b0100; tbl.push_back(v);
        v = idle_vec(); v.spn = 1; v.wmask = 4'b1111; v.pc = 32'h400;
        v = ex(v, 4'b1111, 4'b0000, 16'h161F, 4'b0001); v.e_spn = 1; v.e_swm = 4'b0010; tbl.push_back(v);

        reset_and_boot("rst");

        for (int i = 0; i < tbl.size(); i++) begin
            drive_cycle(tbl[i]);
            check_all($sformatf("vec%0d", i), tbl[i].e_act, tbl[i].e_stl, tbl[i].e_msk,
                      tbl[i].e_err, tbl[i].e_rdr, tbl[i].wid, tbl[i].pc,
                      tbl[i].e_spn, tbl[i].e_swm, tbl[i].pc,
                      tbl[i].e_gbr, tbl[i].bid, tbl[i].sz);
        end

        // Nested divergence on warp 3: four splits fill the 8-entry stack,
        // the fifth is dropped and flags overflow.
        for (int k = 0; k < 5; k++) begin
            v = idle_vec(); v.wid = 3; v.spl = 1; v.dvg = 1;
            v.thn = 4'(k + 1); v.els = ~4'(k + 1); v.pc = 32'h1000 + k;
            drive_cycle(v);
            check($sformatf("nest%0d.mask", k), thread_masks[15:12], (k < 4) ? 4'(k + 1) : 4'd4);
            check($sformatf("nest%0d.err", k), ipdom_err, (k < 4) ? 4'b0001 : 4'b1001);
        end
        v = idle_vec(); v.wid = 3; v.jn = 1; v.dvg = 1;
        drive_cycle(v);
        check("nest.join.redir_v", redirect_valid, 1'b1);
        check("nest.join.redir_wid", redirect_wid, 2'd3);
        check("nest.join.redir_pc", redirect_pc, 32'h1003);
        check("nest.join.mask", thread_masks[15:12], 4'b1011);

        // Leave a waiter on local barrier 0, then reset mid-operation.
        v = idle_vec(); v.wid = 1; v.bar = 1; v.bid = 0; v.sz = 1;
        drive_cycle(v);
        check("pre_rst.stalled", stalled_warps, 4'b0010);
        reset_and_boot("midrst");
        v = idle_vec(); v.wid = 3; v.jn = 1; v.dvg = 1;
        drive_cycle(v);
        check("midrst.join.err", ipdom_err, 4'b1000);
        check("midrst.join.redir_v", redirect_valid, 1'b0);
        v = idle_vec(); v.wid = 2; v.bar = 1; v.bid = 0; v.sz = 1;
        drive_cycle(v);
        check("midrst.bar.stalled", stalled_warps, 4'b0100);

        // Randomized run against the reference model.
        reset_and_boot("rnd");
        model_reset();
        for (int c = 0; c < 400; c++) begin
            int r;
            @(negedge clk);
            wctl_valid       = ($urandom_range(0, 3) != 0);
            wctl_wid         = 2'($urandom);
            tmc_valid        = ($urandom_range(0, 3) == 0);
            tmc_tmask        = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
            wspawn_valid     = ($urandom_range(0, 5) == 0);
            wspawn_wmask     = 4'($urandom);
            wspawn_pc        = $urandom;
            r                = int'($urandom_range(0, 5));
            split_valid      = (r < 2);
            join_valid       = (r == 2 || r == 3);
            split_is_dvg     = ($urandom_range(0, 3) != 0);
            join_is_dvg      = ($urandom_range(0, 3) != 0);
            split_then_tmask = 4'($urandom);
            split_else_tmask = 4'($urandom);
            split_next_pc    = $urandom;
            bar_valid        = ($urandom_range(0, 4) == 0);
            bar_id           = 2'($urandom);
            bar_is_global    = ($urandom_range(0, 2) == 0);
            bar_size_m1      = 2'($urandom);
            gbar_rsp_valid   = ($urandom_range(0, 5) == 0);
            gbar_rsp_id      = 2'($urandom);
            model_step();
            @(posedge clk);
            #1;
            check_all($sformatf("rnd%0d", c), m_active, m_stalled,
                      {m_mask[3], m_mask[2], m_mask[1], m_mask[0]}, m_err,
                      e_rdr, e_rwid, e_rpc, e_spn, e_swm, e_spc, e_gbr, e_gid, e_gsz);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Hard bound on simulated time so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
